// File: rtl/pc_unit_ras_pkg.sv
// Shared definitions for the program-counter unit with return-address stack.
// Holds the branch-condition encodings, a ceil-log2 helper for sizing
// select/pointer fields, and the default reset and exception-vector constants.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        BR_Z      = 2'd0,
        BR_NZ     = 2'd1,
        BR_ALWAYS = 2'd2,
        BR_NEVER  = 2'd3
    } br_cond_e;

    localparam int unsigned DEF_RESET_PC   = 32'h0000_0000;
    localparam int unsigned DEF_EXC_VECTOR = 32'h0000_0010;

    // Smallest r with 2**r >= v (clog2(1) = 0).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_unit_ras_if.sv
// Control/status bundle between decode and the PC unit.
// slave : PC unit side (takes control, drives pc/RAS status).
// master: control side (drives control, observes pc/RAS status).
// Optional exc_req/epc pair is present only with PCU_EXCEPTION_EN defined.
interface pc_unit_ras_if #(
    parameter int unsigned PC_W      = 16,
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned SEL_W = pc_unit_pkg::clog2(N_SRC);
    localparam int unsigned CNT_W = pc_unit_pkg::clog2(RAS_DEPTH) + 1;

    logic                    stall;
    logic                    pc_write;
    logic                    is_branch;
    logic [1:0]              branch_cond;
    logic                    is_zero;
    logic [SEL_W-1:0]        pc_src;
    logic [N_SRC*PC_W-1:0]   src_data;
    logic                    is_call;
    logic                    is_ret;
    logic [PC_W-1:0]         pc;
    logic [PC_W-1:0]         pc_plus_inc;
    logic [CNT_W-1:0]        ras_count;
    logic                    ras_empty;
    logic                    ras_full;
    logic                    ras_overflow;
    logic                    ras_underflow;
    logic                    ctl_err;
`ifdef PCU_EXCEPTION_EN
    logic                    exc_req;
    logic [PC_W-1:0]         epc;
`endif

    modport master (
        output stall, pc_write, is_branch, branch_cond, is_zero, pc_src, src_data,
               is_call, is_ret,
`ifdef PCU_EXCEPTION_EN
        output exc_req,
        input  epc,
`endif
        input  pc, pc_plus_inc, ras_count, ras_empty, ras_full,
               ras_overflow, ras_underflow, ctl_err
    );

    modport slave (
        input  stall, pc_write, is_branch, branch_cond, is_zero, pc_src, src_data,
               is_call, is_ret,
`ifdef PCU_EXCEPTION_EN
        input  exc_req,
        output epc,
`endif
        output pc, pc_plus_inc, ras_count, ras_empty, ras_full,
               ras_overflow, ras_underflow, ctl_err
    );

endinterface

// File: rtl/pc_unit_ras_ras_stack.sv
// Circular return-address LIFO.
// Ports: clk, rst_n; push_i/pop_i requests (push wins if both), push_data_i;
// top_c (current top entry), count_o (valid entries), full_c, empty_c,
// ovf_c (push while full, oldest entry overwritten), unf_c (pop while empty).
module ras_stack
    import pc_unit_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned W     = 16,
    localparam int unsigned CNT_W = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     push_data_i,
    output logic [W-1:0]     top_c,
    output logic [CNT_W-1:0] count_o,
    output logic             full_c,
    output logic             empty_c,
    output logic             ovf_c,
    output logic             unf_c
);
    localparam int unsigned PTR_W = clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] tos_q, tos_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);
    assign do_pop  = pop_i & ~push_i & ~empty_c;
    assign ovf_c   = push_i & full_c;
    assign unf_c   = pop_i & ~push_i & empty_c;
    assign top_c   = mem_q[tos_q];
    assign count_o = count_q;

    // Top pointer wraps naturally because DEPTH is a power of two; when full,
    // the slot after the top holds the oldest entry and gets overwritten.
    always_comb begin
        tos_d   = tos_q;
        count_d = count_q;
        if (push_i) begin
            tos_d = tos_q + PTR_W'(1);
            if (!full_c) count_d = count_q + CNT_W'(1);
        end else if (do_pop) begin
            tos_d   = tos_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos_q   <= PTR_W'(DEPTH - 1);
            count_q <= '0;
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once pushed.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[tos_d] <= push_data_i;
    end

endmodule

// File: rtl/pc_unit_ras.sv
// Program-counter unit: PC register, N-way next-PC select, write/branch gating,
// circular return-address stack for call/return, and stall.
// Ports: CLK, RST_N (async active-low), bus (pc_unit_ras_if.slave) carrying
// control inputs and pc, pc_plus_inc (combinational), RAS occupancy and
// sticky error flags.
// Optional macro PCU_EXCEPTION_EN adds exc_req/epc and the EXC_VECTOR parameter;
// exceptions override stall and leave the RAS untouched.
module pc_unit_ras
    import pc_unit_pkg::*;
#(
    parameter int unsigned     PC_W       = 16,
    parameter int unsigned     N_SRC      = 4,
    parameter int unsigned     RAS_DEPTH  = 4,
    parameter int unsigned     PC_INC     = 2,
    parameter logic [PC_W-1:0] RESET_PC   = PC_W'(DEF_RESET_PC)
`ifdef PCU_EXCEPTION_EN
   ,parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(DEF_EXC_VECTOR)
`endif
) (
    input logic          CLK,
    input logic          RST_N,
    pc_unit_ras_if.slave bus
);
    localparam int unsigned SEL_W = clog2(N_SRC);
    localparam int unsigned CNT_W = clog2(RAS_DEPTH) + 1;

    logic [PC_W-1:0]  pc_q, pc_d, pc_inc_c, sel_pc;
    logic [PC_W-1:0]  src_arr [N_SRC];
    logic             ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
    logic             cond_met, commit, sel_err;
    logic             ras_push, ras_pop, ras_full, ras_empty, ras_ovf, ras_unf;
    logic [PC_W-1:0]  ras_top;
    logic [CNT_W-1:0] ras_count;
`ifdef PCU_EXCEPTION_EN
    logic [PC_W-1:0]  epc_q, epc_d;
`endif

    // Unpack the flat source bus into addressable slots.
    always_comb begin
        for (int unsigned k = 0; k < N_SRC; k++) begin
            src_arr[k] = bus.src_data[k*PC_W +: PC_W];
        end
    end

    // Out-of-range selects only exist when N_SRC is not a power of two.
    if (N_SRC < (32'd1 << SEL_W)) begin : g_sel_chk
        assign sel_err = (32'(bus.pc_src) >= N_SRC);
    end else begin : g_sel_nochk
        assign sel_err = 1'b0;
    end

    assign sel_pc   = sel_err ? src_arr[0] : src_arr[bus.pc_src];
    assign pc_inc_c = pc_q + PC_W'(PC_INC);

    always_comb begin
        cond_met = 1'b0;
        case (br_cond_e'(bus.branch_cond))
            BR_Z:      cond_met = bus.is_zero;
            BR_NZ:     cond_met = ~bus.is_zero;
            BR_ALWAYS: cond_met = 1'b1;
            BR_NEVER:  cond_met = 1'b0;
            default:   cond_met = 1'b0;
        endcase
    end

    assign commit = bus.pc_write | (bus.is_branch & cond_met);

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk         (CLK),
        .rst_n       (RST_N),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_inc_c),
        .top_c       (ras_top),
        .count_o     (ras_count),
        .full_c      (ras_full),
        .empty_c     (ras_empty),
        .ovf_c       (ras_ovf),
        .unf_c       (ras_unf)
    );

    // Next-state: exception > stall > return > commit > hold.
    always_comb begin
        pc_d     = pc_q;
        err_d    = err_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
`ifdef PCU_EXCEPTION_EN
        epc_d    = epc_q;
        if (bus.exc_req) begin
            epc_d = pc_q;
            pc_d  = EXC_VECTOR;
        end else
`endif
        if (!bus.stall) begin
            if (bus.is_ret) begin
                ras_pop = 1'b1;
                pc_d    = ras_empty ? RESET_PC : ras_top;
                if (bus.is_call) err_d = 1'b1;
            end else if (commit) begin
                pc_d     = sel_pc;
                ras_push = bus.is_call;
                if (sel_err) err_d = 1'b1;
            end
        end
    end

    // Stack pulses only fire on gated push/pop, so they can feed the sticky bits directly.
    assign ovf_d = ovf_q | ras_ovf;
    assign unf_d = unf_q | ras_unf;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q  <= RESET_PC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            err_q <= 1'b0;
`ifdef PCU_EXCEPTION_EN
            epc_q <= '0;
`endif
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            err_q <= err_d;
`ifdef PCU_EXCEPTION_EN
            epc_q <= epc_d;
`endif
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus_inc   = pc_inc_c;
    assign bus.ras_count     = ras_count;
    assign bus.ras_empty     = ras_empty;
    assign bus.ras_full      = ras_full;
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = unf_q;
    assign bus.ctl_err       = err_q;
`ifdef PCU_EXCEPTION_EN
    assign bus.epc           = epc_q;
`endif

endmodule

// File: tb/tb_pc_unit_ras.sv
// Self-checking bench for pc_unit_ras: a queue-based reference model checked
// every cycle, plus directed sequences with hand-computed literal expectations.
module tb_pc_unit_ras;
    localparam int unsigned PC_W  = 16;
    localparam int unsigned N_SRC = 4;
    localparam int unsigned DEPTH = 4;
    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] EXC_V  = 16'h0010;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    pc_unit_ras_if #(.PC_W(PC_W), .N_SRC(N_SRC), .RAS_DEPTH(DEPTH)) bus ();

    pc_unit_ras #(
        .PC_W      (PC_W),
        .N_SRC     (N_SRC),
        .RAS_DEPTH (DEPTH),
        .PC_INC    (2),
        .RESET_PC  (RST_PC)
`ifdef PCU_EXCEPTION_EN
       ,.EXC_VECTOR(EXC_V)
`endif
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    logic [15:0] m_pc;
    logic [15:0] m_ras [$];
    bit          m_ovf, m_unf, m_err, m_exc;
    logic [15:0] m_epc;
    logic [63:0] m_sd;
    logic [15:0] m_ret;
    int          m_idx;
    bit          m_commit;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_pc = RST_PC;
            m_ras.delete();
            m_ovf = 0; m_unf = 0; m_err = 0;
            m_epc = 16'h0;
        end else begin
            m_exc = 0;
`ifdef PCU_EXCEPTION_EN
            m_exc = bus.exc_req;
`endif
            if (m_exc) begin
                m_epc = m_pc;
                m_pc  = EXC_V;
            end else if (!bus.stall) begin
                m_commit = bus.pc_write ||
                           (bus.is_branch && ((bus.branch_cond == 2'd0 && bus.is_zero) ||
                                              (bus.branch_cond == 2'd1 && !bus.is_zero) ||
                                              (bus.branch_cond == 2'd2)));
                if (bus.is_ret) begin
                    if (bus.is_call) m_err = 1;
                    if (m_ras.size() == 0) begin
                        m_pc  = RST_PC;
                        m_unf = 1;
                    end else begin
                        m_pc = m_ras.pop_back();
                    end
                end else if (m_commit) begin
                    m_ret = 16'(m_pc + 16'd2);
                    m_idx = int'(bus.pc_src);
                    if (m_idx >= int'(N_SRC)) begin
                        m_idx = 0;
                        m_err = 1;
                    end
                    m_sd = bus.src_data;
                    m_pc = m_sd[m_idx*16 +: 16];
                    if (bus.is_call) begin
                        if (m_ras.size() == int'(DEPTH)) begin
                            void'(m_ras.pop_front());
                            m_ovf = 1;
                        end
                        m_ras.push_back(m_ret);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_pc",        32'(bus.pc),            32'(m_pc));
            chk("m_pc_inc",    32'(bus.pc_plus_inc),   32'(16'(m_pc + 16'd2)));
            chk("m_ras_count", 32'(bus.ras_count),     32'(m_ras.size()));
            chk("m_empty",     32'(bus.ras_empty),     32'(m_ras.size() == 0));
            chk("m_full",      32'(bus.ras_full),      32'(m_ras.size() == int'(DEPTH)));
            chk("m_ovf",       32'(bus.ras_overflow),  32'(m_ovf));
            chk("m_unf",       32'(bus.ras_underflow), 32'(m_unf));
            chk("m_err",       32'(bus.ctl_err),       32'(m_err));
`ifdef PCU_EXCEPTION_EN
            chk("m_epc",       32'(bus.epc),           32'(m_epc));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clr();
        bus.stall       = 0;
        bus.pc_write    = 0;
        bus.is_branch   = 0;
        bus.branch_cond = 2'd0;
        bus.is_zero     = 0;
        bus.pc_src      = 2'd0;
        bus.is_call     = 0;
        bus.is_ret      = 0;
`ifdef PCU_EXCEPTION_EN
        bus.exc_req     = 0;
`endif
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic set_pc(input logic [15:0] v);
        clr();
        bus.pc_write       = 1;
        bus.src_data[15:0] = v;
        step();
        clr();
    endtask

    task automatic call_to(input logic [15:0] tgt);
        clr();
        bus.pc_write       = 1;
        bus.is_call        = 1;
        bus.src_data[15:0] = tgt;
        step();
    endtask

    int unsigned  sweep [4]  = '{127, 126, 128, 2047};
    logic [15:0]  rets  [4]  = '{16'h1402, 16'h1302, 16'h1202, 16'h1102};

    initial begin
        clr();
        bus.src_data = {16'd2047, 16'd128, 16'd126, 16'd127};
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_pc",    32'(bus.pc),        32'h0);
        chk("rst_empty", 32'(bus.ras_empty), 32'h1);
        chk("rst_full",  32'(bus.ras_full),  32'h0);
        chk("rst_count", 32'(bus.ras_count), 32'h0);
        @(negedge CLK);
        RST_N  = 1;
        chk_en = 1;

        // Idle: no update
        step();
        chk("idle_pc",    32'(bus.pc),        32'h0);
        chk("idle_empty", 32'(bus.ras_empty), 32'h1);

        // Branch on zero
        bus.is_branch = 1; bus.branch_cond = 2'd0; bus.is_zero = 0; bus.pc_src = 2'd1;
        step();
        chk("bz_nottaken", 32'(bus.pc), 32'h0);
        bus.is_zero = 1;
        step();
        chk("bz_taken", 32'(bus.pc), 32'd126);

        // Unconditional write, source sweep
        clr();
        bus.pc_write = 1;
        for (int i = 0; i < 4; i++) begin
            bus.pc_src = 2'(i);
            step();
            chk("sweep", 32'(bus.pc), 32'(sweep[i]));
        end

        // Other branch conditions, and pc_write overriding a never-branch
        clr();
        bus.is_branch = 1; bus.branch_cond = 2'd1; bus.is_zero = 0; bus.pc_src = 2'd2;
        step();
        chk("bnz_taken", 32'(bus.pc), 32'd128);
        bus.branch_cond = 2'd3; bus.pc_src = 2'd3;
        step();
        chk("bnever", 32'(bus.pc), 32'd128);
        bus.branch_cond = 2'd2;
        step();
        chk("balways", 32'(bus.pc), 32'd2047);
        bus.branch_cond = 2'd3; bus.pc_write = 1; bus.pc_src = 2'd0;
        step();
        chk("write_over_branch", 32'(bus.pc), 32'd127);

        // Nested call / return
        set_pc(16'h0100);
        call_to(16'h0200);
        chk("call1_pc",  32'(bus.pc),        32'h0200);
        chk("call1_cnt", 32'(bus.ras_count), 32'd1);
        call_to(16'h0300);
        chk("call2_pc",  32'(bus.pc),        32'h0300);
        chk("call2_cnt", 32'(bus.ras_count), 32'd2);
        clr();
        bus.is_ret = 1;
        step();
        chk("ret1_pc",  32'(bus.pc),        32'h0202);
        chk("ret1_cnt", 32'(bus.ras_count), 32'd1);
        step();
        chk("ret2_pc",  32'(bus.pc),        32'h0102);
        chk("ret2_cnt", 32'(bus.ras_count), 32'd0);

        // Call without commit: no push
        clr();
        bus.is_call = 1; bus.is_branch = 1; bus.branch_cond = 2'd3;
        step();
        chk("nocommit_cnt", 32'(bus.ras_count), 32'd0);
        chk("nocommit_pc",  32'(bus.pc),        32'h0102);

        // Overflow then underflow
        set_pc(16'h1000);
        for (int i = 1; i <= 5; i++) call_to(16'(16'h1000 + 16'(i) * 16'h0100));
        chk("ovf_flag", 32'(bus.ras_overflow), 32'd1);
        chk("ovf_cnt",  32'(bus.ras_count),    32'd4);
        chk("ovf_full", 32'(bus.ras_full),     32'd1);
        chk("ovf_pc",   32'(bus.pc),           32'h1500);
        clr();
        bus.is_ret = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ovf_ret", 32'(bus.pc), 32'(rets[i]));
        end
        chk("unf_pre", 32'(bus.ras_underflow), 32'd0);
        step();
        chk("unf_pc",   32'(bus.pc),            32'h0);
        chk("unf_flag", 32'(bus.ras_underflow), 32'd1);
        chk("unf_cnt",  32'(bus.ras_count),     32'd0);

        // Call and return together: return wins, ctl_err set
        set_pc(16'h0100);
        call_to(16'h0200);
        bus.is_ret = 1;
        step();
        chk("callret_pc",  32'(bus.pc),        32'h0102);
        chk("callret_cnt", 32'(bus.ras_count), 32'd0);
        chk("callret_err", 32'(bus.ctl_err),   32'd1);

        // Stall freezes everything
        set_pc(16'h0500);
        call_to(16'h0600);
        clr();
        bus.stall = 1; bus.pc_write = 1; bus.is_call = 1; bus.src_data[15:0] = 16'h0700;
        step();
        step();
        chk("stall_pc",  32'(bus.pc),        32'h0600);
        chk("stall_cnt", 32'(bus.ras_count), 32'd1);
        bus.pc_write = 0; bus.is_call = 0; bus.is_ret = 1;
        step();
        chk("stall_ret_pc",  32'(bus.pc),        32'h0600);
        chk("stall_ret_cnt", 32'(bus.ras_count), 32'd1);

        // Async reset mid-stall
        @(posedge CLK);
        #2;
        RST_N = 0;
        #1;
        chk("arst_pc",  32'(bus.pc),            32'h0);
        chk("arst_cnt", 32'(bus.ras_count),     32'd0);
        chk("arst_ovf", 32'(bus.ras_overflow),  32'd0);
        chk("arst_unf", 32'(bus.ras_underflow), 32'd0);
        chk("arst_err", 32'(bus.ctl_err),       32'd0);
        @(negedge CLK);
        RST_N = 1;
        step();
        chk("arst_hold_pc", 32'(bus.pc), 32'h0);
        clr();

`ifdef PCU_EXCEPTION_EN
        // Exception overrides stall
        set_pc(16'h0040);
        bus.stall = 1; bus.exc_req = 1;
        step();
        chk("exc_pc",  32'(bus.pc),  32'h0010);
        chk("exc_epc", 32'(bus.epc), 32'h0040);
        clr();
`endif

        step();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
